// File: rtl/branch_seq_pkg.sv
// Shared definitions for the branch sequencer: opcode encodings seen on the op port.
package branch_seq_pkg;

  typedef enum logic [1:0] {
    OP_SEQ  = 2'b00,
    OP_JMP  = 2'b01,
    OP_CALL = 2'b10,
    OP_RET  = 2'b11
  } op_e;

endpackage

// File: rtl/branch_seq_ret_stack.sv
// Return-address LIFO addressed by its occupancy count: push writes entry[sp],
// pop exposes entry[sp-1] on rdata.
module ret_stack #(
  parameter int PC_W        = 8,
  parameter int STACK_DEPTH = 4,
  localparam int SP_W       = $clog2(STACK_DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic [PC_W-1:0] wdata,
  output logic [PC_W-1:0] rdata,
  output logic [SP_W-1:0] sp,
  output logic            full,
  output logic            empty
);

  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [PC_W-1:0] mem [STACK_DEPTH];
  logic [SP_W-1:0] sp_dec;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;

  assign full   = (sp == SP_W'(STACK_DEPTH));
  assign empty  = (sp == '0);
  assign sp_dec = sp - SP_W'(1);
  // Occupancy below STACK_DEPTH always fits the narrower entry index.
  assign wr_idx = sp[IDX_W-1:0];
  assign rd_idx = sp_dec[IDX_W-1:0];
  assign rdata  = empty ? '0 : mem[rd_idx];

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp <= '0;
    end else if (push && !full) begin
      sp <= sp + SP_W'(1);
    end else if (pop && !empty) begin
      sp <= sp_dec;
    end
  end

  // NOTE: entry storage is deliberately not reset; sp=0 already marks it
  // invalid, and leaving it reset-free lets it map onto plain RAM/flops.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_idx] <= wdata;
    end
  end

endmodule

// File: rtl/branch_seq.sv
// Program-counter sequencer: resolves conditional JMP/CALL/RET against the
// condition bit and keeps return addresses in a small LIFO.
module branch_seq
  import branch_seq_pkg::*;
#(
  parameter int              PC_W        = 8,
  parameter int              STACK_DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_PC    = '0,
  localparam int             SP_W        = $clog2(STACK_DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic [1:0]      op,
  input  logic            cond,
  input  logic [PC_W-1:0] target,
  output logic [PC_W-1:0] pc,
  output logic            taken,
  output logic [SP_W-1:0] sp,
  output logic            stack_err
);

  op_e             op_d;
  logic [PC_W-1:0] inc;
  logic [PC_W-1:0] pc_next;
  logic [PC_W-1:0] rdata;
  logic            taken_next;
  logic            err_next;
  logic            push;
  logic            pop;
  logic            full;
  logic            empty;

  assign op_d = op_e'(op);
  assign inc  = pc + PC_W'(1);

  ret_stack #(
    .PC_W        (PC_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (inc),
    .rdata (rdata),
    .sp    (sp),
    .full  (full),
    .empty (empty)
  );

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    pc_next    = pc;
    taken_next = 1'b0;
    err_next   = stack_err;
    push       = 1'b0;
    pop        = 1'b0;
    if (!stall) begin
      pc_next = inc;
      case (op_d)
        OP_JMP: begin
          if (cond) begin
            pc_next    = target;
            taken_next = 1'b1;
          end
        end
        OP_CALL: begin
          if (cond) begin
            if (!full) begin
              push       = 1'b1;
              pc_next    = target;
              taken_next = 1'b1;
            end else begin
              err_next = 1'b1;
            end
          end
        end
        OP_RET: begin
          if (cond) begin
            if (!empty) begin
              pop        = 1'b1;
              pc_next    = rdata;
              taken_next = 1'b1;
            end else begin
              err_next = 1'b1;
            end
          end
        end
        default: ;  // SEQ: cond is not looked at, so X there is harmless
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc        <= RESET_PC;
      taken     <= 1'b0;
      stack_err <= 1'b0;
    end else begin
      pc        <= pc_next;
      taken     <= taken_next;
      stack_err <= err_next;
    end
  end

endmodule
